display_mux: RTL

DISPLAY_MUX -- requirements
Module: display_mux

---
 rtl/seg7_pkg.sv | 71 +++++++
 rtl/seg7_glyph.sv | 26 ++
 rtl/display_mux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants (gfedcba, active-low) and the glyph-index type
// shared by the display multiplexer and its glyph decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [4:0] {
    GI_0     = 5'd0,
    GI_1     = 5'd1,
    GI_2     = 5'd2,
    GI_3     = 5'd3,
    GI_4     = 5'd4,
    GI_5     = 5'd5,
    GI_6     = 5'd6,
    GI_7     = 5'd7,
    GI_8     = 5'd8,
    GI_9     = 5'd9,
    GI_A     = 5'd10,
    GI_B     = 5'd11,
    GI_C     = 5'd12,
    GI_D     = 5'd13,
    GI_E     = 5'd14,
    GI_F     = 5'd15,
    GI_DASH  = 5'd16,
    GI_BLANK = 5'd17
  } glyph_idx_t;

  function automatic logic [6:0] glyph_seg(input glyph_idx_t gi);
    logic [6:0] s;
    case (gi)
      GI_0:     s = SEG_0;
      GI_1:     s = SEG_1;
      GI_2:     s = SEG_2;
      GI_3:     s = SEG_3;
      GI_4:     s = SEG_4;
      GI_5:     s = SEG_5;
      GI_6:     s = SEG_6;
      GI_7:     s = SEG_7;
      GI_8:     s = SEG_8;
      GI_9:     s = SEG_9;
      GI_A:     s = SEG_A;
      GI_B:     s = SEG_B;
      GI_C:     s = SEG_C;
      GI_D:     s = SEG_D;
      GI_E:     s = SEG_E;
      GI_F:     s = SEG_F;
      GI_DASH:  s = SEG_DASH;
      GI_BLANK: s = SEG_BLANK;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-segment decoder; blank beats dash, dash beats the hex glyph.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dash_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  glyph_idx_t gi_s;

  // Resolve the glyph index by priority, then look up its segment pattern.
  always_comb begin
    gi_s = GI_BLANK;
    if (blank_i) begin
      gi_s = GI_BLANK;
    end else if (dash_i) begin
      gi_s = GI_DASH;
    end else begin
      gi_s = glyph_idx_t'({1'b0, nibble_i});
    end
    seg_o = glyph_seg(gi_s);
  end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed seven-segment driver with double-buffered digit data
// (staging captured on load, shadow swapped at frame wrap) and a ghost-guard cycle.
module display_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   dash_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int ST_W  = 7 * N_DIGITS;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tick_q, tick_d;
  logic [ST_W-1:0]     stg_q, stg_d;
  logic [ST_W-1:0]     shd_q, shd_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic [ST_W-1:0]       in_vec_s;
  logic [4*N_DIGITS-1:0] shd_val_s;
  logic [N_DIGITS-1:0]   shd_dp_s, shd_blank_s, shd_dash_s;
  logic [N_DIGITS-1:0]   dig_sel_s, lz_mask_s;
  logic                  zero_run_s;
  logic [3:0]            sel_nib_s;
  logic                  sel_dp_s, sel_blank_s, sel_dash_s, sel_lz_s, dark_s;
  logic [6:0]            glyph_out_s;

  // Staging and shadow words share one layout: {dash, blank, dp, value}.
  assign in_vec_s = {dash_in, blank_in, dp_in, value};
  assign {shd_dash_s, shd_blank_s, shd_dp_s, shd_val_s} = shd_q;

  // Refresh divider and digit index; frame tick is raised as the index wraps to 0.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d = '0;
      if (idx_q == IDX_W'(N_DIGITS - 1)) begin
        idx_d  = '0;
        tick_d = 1'b1;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        tick_d = 1'b0;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Staging follows load; shadow swaps only on the frame tick, bypassing a coincident load.
  always_comb begin
    stg_d = stg_q;
    shd_d = shd_q;
    if (load) begin
      stg_d = in_vec_s;
    end else begin
      stg_d = stg_q;
    end
    if (tick_q) begin
      shd_d = load ? in_vec_s : stg_q;
    end else begin
      shd_d = shd_q;
    end
  end

  // Leading-zero mask scanned from the top digit down, then one-hot digit selection.
  always_comb begin
    lz_mask_s  = '0;
    zero_run_s = 1'b1;
    dig_sel_s  = '0;
    sel_nib_s  = 4'h0;
    sel_dp_s   = 1'b0;
    sel_blank_s = 1'b0;
    sel_dash_s = 1'b0;
    sel_lz_s   = 1'b0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run_s   = zero_run_s & (shd_val_s[4*k +: 4] == 4'h0) & ~shd_dash_s[k] & ~shd_dp_s[k];
      lz_mask_s[k] = zero_run_s & (LZ_SUPPRESS != 0);
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      dig_sel_s[k] = (idx_q == IDX_W'(k));
      sel_nib_s    = sel_nib_s | (shd_val_s[4*k +: 4] & {4{dig_sel_s[k]}});
      sel_dp_s     = sel_dp_s | (shd_dp_s[k] & dig_sel_s[k]);
      sel_blank_s  = sel_blank_s | (shd_blank_s[k] & dig_sel_s[k]);
      sel_dash_s   = sel_dash_s | (shd_dash_s[k] & dig_sel_s[k]);
      sel_lz_s     = sel_lz_s | (lz_mask_s[k] & dig_sel_s[k]);
    end
  end

  assign dark_s = sel_blank_s | sel_lz_s;

  seg7_glyph u_glyph (
    .nibble_i (sel_nib_s),
    .dash_i   (sel_dash_s),
    .blank_i  (dark_s),
    .seg_o    (glyph_out_s)
  );

  // Output next-state: everything dark in the ghost cycle or for a blanked digit.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if ((div_q == '0) || dark_s) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      an_d  = '1;
    end else begin
      seg_d = glyph_out_s;
      dp_d  = ~sel_dp_s;
      an_d  = ~dig_sel_s;
    end
  end

  // State and registered outputs; reset aborts the scan immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
      stg_q  <= '0;
      shd_q  <= '0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      an_q   <= '1;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
      stg_q  <= stg_d;
      shd_q  <= shd_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
